// File: rtl/bus_arbiter4_pkg.sv
// Shared constants for the four-way round-robin bus arbiter.
// State encodings and requester count used by the arbiter and its bench.
package bus_arbiter4_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/bus_arbiter4_mux2.sv
// Four-input data steering mux with a 2-bit address.
// Drives the shared bus from the currently selected requester.
module mux2 #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        unique case (addr)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter sharing one bus among four masters.
// Registered one-hot grant with a hold limit under contention.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             preempt,
    output logic [WIDTH-1:0] bus_out
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    logic [0:0]    state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [3:0]    gnt_n;
    logic [1:0]    sel_n;
    logic          busy_n, preempt_n;
    logic          do_grant;
    logic [1:0]    win;

    // First requester after last, wrapping back to last itself.
    function automatic logic [1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [1:0]         last
    );
        logic [1:0] idx;
        logic       hit;
        rr_pick = last;
        hit     = 1'b0;
        for (int j = 1; j <= NUM_REQ; j++) begin
            idx = last + 2'(j);
            if (!hit && r[idx]) begin
                hit     = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

    assign win = rr_pick(req, ptr);

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        gnt_n     = gnt;
        sel_n     = sel;
        busy_n    = busy;
        preempt_n = 1'b0;
        do_grant  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                do_grant = |req;
            end
            ST_GRANT: begin
                if (!req[ptr]) begin
                    if (|req) begin
                        do_grant = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        gnt_n   = 4'b0000;
                        busy_n  = 1'b0;
                    end
                end else if (hold_cnt == HMAX && |(req & ~gnt)) begin
                    do_grant  = 1'b1;
                    preempt_n = 1'b1;
                end else if (hold_cnt != HMAX) begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
        endcase
        if (do_grant) begin
            state_n = ST_GRANT;
            gnt_n   = 4'b0001 << win;
            sel_n   = win;
            ptr_n   = win;
            busy_n  = 1'b1;
            hold_n  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            ptr      <= 2'd3;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            busy     <= busy_n;
            preempt  <= preempt_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    mux2 #(.WIDTH(WIDTH)) u_mux (
        .addr (sel),
        .d0   (in0),
        .d1   (in1),
        .d2   (in2),
        .d3   (in3),
        .y    (bus_out)
    );

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: directed scenarios plus random traffic.
// Two instances: hold limit 8 and hold limit 1.
module tb_bus_arbiter4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req1;
    logic [15:0] din [4];
    logic [3:0]  gnt, gnt1;
    logic [1:0]  sel, sel1;
    logic        busy, busy1, preempt, preempt1;
    logic [15:0] bus_out, bus_out1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: [0] = MAX_HOLD 8, [1] = MAX_HOLD 1.
    logic [3:0] m_gnt  [2];
    int         m_sel  [2];
    int         m_ptr  [2];
    int         m_held [2];
    logic       m_busy [2];
    logic       m_pre  [2];

    always #5 clk = ~clk;

    bus_arbiter4 #(.WIDTH(16), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .gnt(gnt), .sel(sel), .busy(busy), .preempt(preempt),
        .bus_out(bus_out)
    );

    bus_arbiter4 #(.WIDTH(16), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .gnt(gnt1), .sel(sel1), .busy(busy1), .preempt(preempt1),
        .bus_out(bus_out1)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_gnt[k]  = 4'b0000;
            m_sel[k]  = 0;
            m_ptr[k]  = 3;
            m_held[k] = 0;
            m_busy[k] = 1'b0;
            m_pre[k]  = 1'b0;
        end
    endtask

    // One clock edge of the arbitration rules, in terms of owner and cycles held.
    task automatic model_step(input int k, input logic [3:0] r, input int mh);
        int w;
        bit give;
        w = -1;
        give = 0;
        for (int j = 1; j <= 4; j++)
            if (w < 0 && r[(m_ptr[k] + j) % 4]) w = (m_ptr[k] + j) % 4;
        m_pre[k] = 1'b0;
        if (!m_busy[k]) begin
            give = (r != 0);
        end else if (!r[m_sel[k]]) begin
            if (r != 0) give = 1;
            else begin
                m_busy[k] = 1'b0;
                m_gnt[k]  = 4'b0000;
            end
        end else if (m_held[k] >= mh && (r & ~(4'b0001 << m_sel[k])) != 0) begin
            give = 1;
            m_pre[k] = 1'b1;
        end else begin
            m_held[k]++;
        end
        if (give) begin
            m_gnt[k]  = 4'b0001 << w;
            m_sel[k]  = w;
            m_ptr[k]  = w;
            m_held[k] = 1;
            m_busy[k] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, req, 8);
        model_step(1, req1, 1);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        req1  = 4'b0000;
        model_reset();
        #3;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || preempt !== 1'b0 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: gnt=%b sel=%0d busy=%b pre=%b, want 0000 0 0 0",
                     gnt, sel, busy, preempt);
        end
        n_checks++;
        if (gnt1 !== 4'b0000 || busy1 !== 1'b0 || preempt1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset1: gnt=%b busy=%b pre=%b, want 0000 0 0",
                     gnt1, busy1, preempt1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_handover();
        req = 4'b1111;
        tick();
        n_checks++;
        if (gnt !== 4'b0001 || gnt !== m_gnt[0]) begin
            n_fail++;
            $display("FAIL first_grant: gnt=%b want 0001", gnt);
        end
        req = 4'b1110;
        tick();
        n_checks++;
        if (gnt !== 4'b0010 || busy !== 1'b1 || gnt !== m_gnt[0]) begin
            n_fail++;
            $display("FAIL handover: gnt=%b busy=%b want 0010 1", gnt, busy);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd1) begin
            n_fail++;
            $display("FAIL release_idle: gnt=%b busy=%b sel=%0d want 0000 0 1",
                     gnt, busy, sel);
        end
    endtask

    task automatic test_solo_hold();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (gnt !== 4'b0100 || preempt !== 1'b0 || gnt !== m_gnt[0]) begin
                n_fail++;
                $display("FAIL solo_hold c%0d: gnt=%b pre=%b want 0100 0",
                         c, gnt, preempt);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_preempt();
        req = 4'b0001;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 2) req = 4'b1001;
            n_checks++;
            if (gnt !== m_gnt[0] || preempt !== m_pre[0]) begin
                n_fail++;
                $display("FAIL preempt_model c%0d: gnt=%b pre=%b want %b %b",
                         c, gnt, preempt, m_gnt[0], m_pre[0]);
            end
            if (c == 8 || c == 9 || c == 10) begin
                n_checks++;
                if (gnt !== (c == 8 ? 4'b0001 : 4'b1000) || preempt !== (c == 9)) begin
                    n_fail++;
                    $display("FAIL preempt_edge c%0d: gnt=%b pre=%b", c, gnt, preempt);
                end
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_rotate();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req1 = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (gnt1 !== exp_seq[c] || gnt1 !== m_gnt[1] || preempt1 !== m_pre[1]) begin
                n_fail++;
                $display("FAIL rotate c%0d: gnt=%b pre=%b want %b %b",
                         c, gnt1, preempt1, exp_seq[c], m_pre[1]);
            end
        end
        req1 = 4'b0000;
        tick();
    endtask

    task automatic test_bus_data();
        logic [3:0] pat [5];
        pat = '{4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0000};
        din[0] = 16'hA0A0;
        din[1] = 16'hB1B1;
        din[2] = 16'hC2C2;
        din[3] = 16'hD3D3;
        for (int c = 0; c < 5; c++) begin
            req = pat[c];
            tick();
            n_checks++;
            if (bus_out !== din[m_sel[0]] || sel !== 2'(m_sel[0]) || busy !== m_busy[0]) begin
                n_fail++;
                $display("FAIL bus_data c%0d: bus=%h sel=%0d busy=%b want %h %0d %b",
                         c, bus_out, sel, busy, din[m_sel[0]], m_sel[0], m_busy[0]);
            end
        end
        n_checks++;
        if (sel !== 2'd2 || busy !== 1'b0 || bus_out !== 16'hC2C2) begin
            n_fail++;
            $display("FAIL idle_sel: sel=%0d busy=%b bus=%h want 2 0 c2c2",
                     sel, busy, bus_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req  = 4'($urandom_range(0, 15));
            req1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = req & 4'b0011;
            for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
            tick();
            n_checks++;
            if (gnt !== m_gnt[0] || sel !== 2'(m_sel[0]) || busy !== m_busy[0] ||
                preempt !== m_pre[0] || bus_out !== din[m_sel[0]]) begin
                n_fail++;
                $display("FAIL random c%0d: gnt=%b sel=%0d busy=%b pre=%b want %b %0d %b %b",
                         c, gnt, sel, busy, preempt, m_gnt[0], m_sel[0], m_busy[0], m_pre[0]);
            end
            n_checks++;
            if (gnt1 !== m_gnt[1] || sel1 !== 2'(m_sel[1]) || busy1 !== m_busy[1] ||
                preempt1 !== m_pre[1]) begin
                n_fail++;
                $display("FAIL random1 c%0d: gnt=%b sel=%0d busy=%b pre=%b want %b %0d %b %b",
                         c, gnt1, sel1, busy1, preempt1, m_gnt[1], m_sel[1], m_busy[1], m_pre[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        req  = 4'b0010;
        req1 = 4'b0100;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt1 !== 4'b0000 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b busy=%b gnt1=%b busy1=%b want zeros",
                     gnt, busy, gnt1, busy1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        req1  = 4'b0000;
        tick();
        n_checks++;
        if (gnt !== 4'b1000 || gnt !== m_gnt[0] || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: gnt=%b busy=%b want 1000 1", gnt, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = 16'h0000;
        test_reset();
        test_handover();
        test_solo_hold();
        test_preempt();
        test_rotate();
        test_bus_data();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
